// File: rtl/fb_access_scheduler.sv
`timescale 1ns/1ps
// fb_access_scheduler: single-port framebuffer arbiter for display reads, queued draw writes and a full-screen clear sweep
module fb_access_scheduler #(
  parameter int X_W        = 7,
  parameter int Y_W        = 7,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_strobe,
  input  logic [X_W-1:0]         wr_x,
  input  logic [Y_W-1:0]         wr_y,
  input  logic [COLOR_W-1:0]     wr_color,
  input  logic                   clear_start,
  input  logic [COLOR_W-1:0]     clear_color,
  input  logic                   rd_req,
  input  logic [X_W+Y_W-1:0]     rd_addr,
  output logic                   rd_grant,
  output logic                   rd_valid,
  output logic [COLOR_W-1:0]     rd_data,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [X_W+Y_W-1:0]     mem_addr,
  output logic [COLOR_W-1:0]     mem_wdata,
  input  logic [COLOR_W-1:0]     mem_rdata,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int A_W = X_W + Y_W;
  localparam int P_W = $clog2(FIFO_DEPTH);
  localparam int D_W = A_W + COLOR_W;
  localparam int W_W = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, PEND, CLEAR} state_t;
  state_t state_q, state_d;
  logic [P_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [P_W:0] count_q, count_d;
  logic [W_W-1:0] wait_q, wait_d;
  logic [A_W-1:0] sweep_q, sweep_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic ovf_q, ovf_d, busy_q, busy_d, rv_q, rv_d;
  logic [D_W-1:0] fifo_q [FIFO_DEPTH];
  logic [D_W-1:0] head;
  logic full, wr_pend, force_wr, rd_gnt, wr_gnt, pop, push;
  logic [A_W-1:0] src_addr;
  logic [COLOR_W-1:0] src_data;
  always_comb begin
    head     = fifo_q[rd_ptr_q];
    full     = count_q == (P_W+1)'(FIFO_DEPTH);
    wr_pend  = (state_q == CLEAR) || (count_q != '0);
    force_wr = wr_pend && (wait_q == W_W'(MAX_WAIT));
    rd_gnt   = !reset && rd_req && !force_wr;
    wr_gnt   = !reset && wr_pend && !rd_gnt;
    pop      = wr_gnt && (state_q != CLEAR);
    push     = (state_q == IDLE) && wr_strobe && (!full || pop);
    ovf_d    = ovf_q | ((state_q == IDLE) && wr_strobe && full && !pop);
    count_d  = count_q + (P_W+1)'(push) - (P_W+1)'(pop);
    wr_ptr_d = wr_ptr_q + P_W'(push);
    rd_ptr_d = rd_ptr_q + P_W'(pop);
    wait_d   = (wr_gnt || !wr_pend) ? '0 :
               (rd_gnt && wait_q != W_W'(MAX_WAIT)) ? wait_q + 1'b1 : wait_q;
    state_d  = state_q == IDLE ? (clear_start ? PEND : IDLE) :
               state_q == PEND ? (count_d == '0 ? CLEAR : PEND) :
               (wr_gnt && &sweep_q) ? IDLE : CLEAR;
    color_d  = (state_q == IDLE && clear_start) ? clear_color : color_q;
    // Held at zero outside CLEAR so each sweep starts from address 0
    sweep_d  = state_q == CLEAR ? sweep_q + A_W'(wr_gnt) : '0;
    busy_d   = (state_d != IDLE) || (count_d != '0);
    rv_d     = rd_gnt;
    src_addr = state_q == CLEAR ? sweep_q : head[D_W-1:COLOR_W];
    src_data = state_q == CLEAR ? color_q : head[COLOR_W-1:0];
    rd_grant   = rd_gnt;
    rd_valid   = rv_q;
    rd_data    = rv_q ? mem_rdata : '0;
    mem_en     = rd_gnt || wr_gnt;
    mem_we     = wr_gnt;
    mem_addr   = rd_gnt ? rd_addr : wr_gnt ? src_addr : '0;
    mem_wdata  = wr_gnt ? src_data : '0;
    busy       = busy_q;
    overflow   = ovf_q;
    fifo_count = count_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      sweep_q  <= '0;
      color_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      sweep_q  <= sweep_d;
      color_q  <= color_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {wr_y, wr_x, wr_color};
  end
endmodule

// File: tb/tb_fb_access_scheduler.sv
`timescale 1ns/1ps
// tb_fb_access_scheduler: directed vector table plus hand sequences for forced writes, overflow, clear sweep and reset abort
module tb_fb_access_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic wr_strobe = 0, clear_start = 0, rd_req = 0;
  logic [6:0] wr_x = 0, wr_y = 0;
  logic [7:0] wr_color = 0, clear_color = 0, mem_rdata = 0;
  logic [13:0] rd_addr = 0;
  logic rd_grant, rd_valid, mem_en, mem_we, busy, overflow;
  logic [7:0] rd_data, mem_wdata;
  logic [13:0] mem_addr;
  logic [2:0] fifo_count;
  int errors = 0, checks = 0;

  fb_access_scheduler dut (
    .clk(clk), .reset(reset), .wr_strobe(wr_strobe), .wr_x(wr_x), .wr_y(wr_y),
    .wr_color(wr_color), .clear_start(clear_start), .clear_color(clear_color),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid),
    .rd_data(rd_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic strb; logic [6:0] x; logic [6:0] y; logic [7:0] col;
    logic rreq; logic [13:0] raddr; logic [7:0] mrd;
    logic en; logic we; logic [13:0] addr; logic [7:0] wd;
    logic gnt; logic rv; logic [7:0] rdd; logic [2:0] cnt; logic bsy;
  } vec_t;
  vec_t vt[11];

  function automatic logic [63:0] outs();
    return {25'd0, mem_en, mem_we, mem_addr, mem_wdata, rd_grant, rd_valid, rd_data, fifo_count, busy, overflow};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic s, input logic [6:0] x, input logic [6:0] y, input logic [7:0] c);
    wr_strobe = s; wr_x = x; wr_y = y; wr_color = c;
  endtask

  initial begin
    int bad;
    logic found;
    vt[0]  = '{0,0,0,8'h00, 0,14'h000,8'h00, 0,0,14'h000,8'h00, 0,0,8'h00,3'd0,0};
    vt[1]  = '{1,5,3,8'hA1, 0,14'h000,8'h00, 0,0,14'h000,8'h00, 0,0,8'h00,3'd0,0};
    vt[2]  = '{0,0,0,8'h00, 0,14'h000,8'h00, 1,1,14'h185,8'hA1, 0,0,8'h00,3'd1,1};
    vt[3]  = '{0,0,0,8'h00, 0,14'h000,8'h00, 0,0,14'h000,8'h00, 0,0,8'h00,3'd0,0};
    vt[4]  = '{0,0,0,8'h00, 1,14'h010,8'h55, 1,0,14'h010,8'h00, 1,0,8'h00,3'd0,0};
    vt[5]  = '{0,0,0,8'h00, 1,14'h010,8'h55, 1,0,14'h010,8'h00, 1,1,8'h55,3'd0,0};
    vt[6]  = '{0,0,0,8'h00, 0,14'h000,8'h55, 0,0,14'h000,8'h00, 0,1,8'h55,3'd0,0};
    vt[7]  = '{0,0,0,8'h00, 0,14'h000,8'h55, 0,0,14'h000,8'h00, 0,0,8'h00,3'd0,0};
    vt[8]  = '{1,1,1,8'h33, 1,14'h020,8'h00, 1,0,14'h020,8'h00, 1,0,8'h00,3'd0,0};
    vt[9]  = '{0,0,0,8'h00, 0,14'h000,8'h77, 1,1,14'h081,8'h33, 0,1,8'h77,3'd1,1};
    vt[10] = '{0,0,0,8'h00, 0,14'h000,8'h00, 0,0,14'h000,8'h00, 0,0,8'h00,3'd0,0};

    @(negedge clk);
    chk("reset_state", outs(), 64'd0);
    next();
    reset = 0;

    for (int i = 0; i < 11; i++) begin
      strobe(vt[i].strb, vt[i].x, vt[i].y, vt[i].col);
      rd_req = vt[i].rreq; rd_addr = vt[i].raddr; mem_rdata = vt[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          {25'd0, vt[i].en, vt[i].we, vt[i].addr, vt[i].wd, vt[i].gnt, vt[i].rv, vt[i].rdd, vt[i].cnt, vt[i].bsy, 1'b0});
      next();
    end
    strobe(0, 0, 0, 0); rd_req = 0; rd_addr = 0; mem_rdata = 0;

    // Forced write after MAX_WAIT denied cycles
    rd_req = 1; rd_addr = 14'h010; strobe(1, 2, 0, 8'h44);
    @(negedge clk);
    chk("maxwait_c0_read", {63'd0, rd_grant}, 64'd1);
    next();
    strobe(0, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      chk($sformatf("maxwait_c%0d", k), {40'd0, rd_grant, mem_we, mem_addr, mem_wdata},
          k == 16 ? {40'd0, 1'b0, 1'b1, 14'h002, 8'h44} : {40'd0, 1'b1, 1'b0, 14'h010, 8'h00});
      next();
    end

    // Overflow: five strobes under continuous reads
    for (int i = 0; i < 5; i++) begin
      strobe(1, 7'(i), 2, 8'hB0 + 8'(i));
      next();
    end
    strobe(0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_flag_count", {60'd0, overflow, fifo_count}, {60'd0, 1'b1, 3'd4});
    next();
    rd_req = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_drain%0d", i), {40'd0, mem_en, mem_we, mem_addr, mem_wdata},
          {40'd0, 1'b1, 1'b1, 14'h100 + 14'(i), 8'hB0 + 8'(i)});
      next();
    end
    @(negedge clk);
    chk("ovf_busy_falls", {60'd0, mem_en, busy, fifo_count}, 64'd0);
    next();

    // Queued writes drain before the clear sweep
    rd_req = 1; strobe(1, 1, 0, 8'hC1);
    next();
    strobe(1, 2, 0, 8'hC2);
    next();
    rd_req = 0; strobe(0, 0, 0, 0); clear_start = 1; clear_color = 8'h0F;
    @(negedge clk);
    chk("clr_fifo_w0", {40'd0, mem_en, mem_we, mem_addr, mem_wdata}, {40'd0, 1'b1, 1'b1, 14'h001, 8'hC1});
    next();
    clear_start = 0; clear_color = 8'hEE;
    @(negedge clk);
    chk("clr_fifo_w1", {40'd0, mem_en, mem_we, mem_addr, mem_wdata}, {40'd0, 1'b1, 1'b1, 14'h002, 8'hC2});
    next();
    bad = 0;
    for (int i = 0; i < 16384; i++) begin
      strobe(i == 6, 3, 3, 8'h99);
      @(negedge clk);
      if (!(mem_en && mem_we && mem_addr == 14'(i) && mem_wdata == 8'h0F && fifo_count == 0 && busy)) bad++;
      next();
    end
    strobe(0, 0, 0, 0);
    chk("clr_sweep_bad_cycles", 64'(bad), 64'd0);
    @(negedge clk);
    chk("clr_done_idle", {59'd0, mem_en, busy, fifo_count, overflow}, {59'd0, 1'b0, 1'b0, 3'd0, 1'b1});
    next();
    @(negedge clk);
    chk("clr_no_residual", {62'd0, mem_en, busy}, 64'd0);
    next();

    // Reset in the middle of a sweep
    clear_start = 1; clear_color = 8'h3C;
    next();
    clear_start = 0;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (mem_we && mem_addr == 14'h100) begin
        found = 1;
        break;
      end
      next();
    end
    chk("rst_reach_0x100", {63'd0, found}, 64'd1);
    reset = 1;
    #1;
    chk("rst_mid_clear", outs(), 64'd0);
    next();
    reset = 0;
    strobe(1, 5, 3, 8'hA1);
    next();
    strobe(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_after_write", {40'd0, mem_en, mem_we, mem_addr, mem_wdata}, {40'd0, 1'b1, 1'b1, 14'h185, 8'hA1});
    next();
    @(negedge clk);
    chk("rst_no_sweep", {62'd0, mem_en, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
